// File: rtl/ysyx_041514_ex_muldiv_if.sv
// EX-stage mul/div port bundle: the pipeline side (master) issues M ops and
// flow-control bits; the mul/div unit (slave) returns its stall request and result.
interface ysyx_041514_ex_muldiv_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [3:0]      op_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            ex_stall_i;
    logic            ex_flush_i;
    logic            stall_req_o;
    logic [XLEN-1:0] result_o;
    logic            result_vld_o;

    modport master (
        output valid_i, op_i, src1_i, src2_i, ex_stall_i, ex_flush_i,
        input  stall_req_o, result_o, result_vld_o
    );

    modport slave (
        input  valid_i, op_i, src1_i, src2_i, ex_stall_i, ex_flush_i,
        output stall_req_o, result_o, result_vld_o
    );
endinterface

// File: rtl/ysyx_041514_ex_muldiv.sv
// Iterative RV64M unit: one radix-2 datapath doing shift-add multiply and
// restoring division on operand magnitudes, with sign fix-up at the end.
module ysyx_041514_ex_muldiv #(
    parameter int XLEN = 64
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_041514_ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    logic [6:0]        cnt;
    logic [3:0]        op_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] opb;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   result_q;
    logic              neg_pq;
    logic              neg_r;
    logic              vld_q;

    logic              is_w, is_div, sgn1, sgn2, neg_a, neg_b;
    logic              div_zero, ovf, special;
    logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, spec_res;
    logic [2*XLEN-1:0] acc_mul, acc_div, acc_nxt, shifted, prod;
    logic [XLEN+1:0]   diff;
    logic [XLEN-1:0]   quo, rem, fin;

    function automatic logic [XLEN-1:0] w_ext(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        is_w   = bus.op_i >= 4'd8 && bus.op_i <= 4'd12;
        is_div = (bus.op_i >= 4'd4 && bus.op_i <= 4'd7) || (bus.op_i >= 4'd9 && bus.op_i <= 4'd12);
        sgn1   = bus.op_i inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
        sgn2   = bus.op_i inside {4'd1, 4'd4, 4'd6, 4'd9, 4'd11};
        a_ext  = is_w ? {{(XLEN-32){sgn1 & bus.src1_i[31]}}, bus.src1_i[31:0]} : bus.src1_i;
        b_ext  = is_w ? {{(XLEN-32){sgn2 & bus.src2_i[31]}}, bus.src2_i[31:0]} : bus.src2_i;
        neg_a  = sgn1 & a_ext[XLEN-1];
        neg_b  = sgn2 & b_ext[XLEN-1];
        mag_a  = neg_a ? -a_ext : a_ext;
        mag_b  = neg_b ? -b_ext : b_ext;
        div_zero = b_ext == '0;
        ovf      = sgn2 && b_ext == '1 &&
                   a_ext == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000);
        special  = bus.op_i > 4'd12 || (is_div && (div_zero || ovf));
        if (bus.op_i > 4'd12)
            spec_res = '0;
        else if (bus.op_i inside {4'd4, 4'd5, 4'd9, 4'd10})
            spec_res = w_ext(is_w, div_zero ? '1 : a_ext);
        else
            spec_res = w_ext(is_w, div_zero ? a_ext : '0);
    end

    // Division keeps remainder in acc[127:64] and dividend/quotient in acc[63:0];
    // acc[127] is carried into the trial subtract so a 65-bit partial remainder is not lost.
    always_comb begin
        acc_mul = acc + (mplier[0] ? opb : '0);
        shifted = {acc[2*XLEN-2:0], 1'b0};
        diff    = {1'b0, acc[2*XLEN-1], shifted[2*XLEN-1:XLEN]} - {2'b0, opb[XLEN-1:0]};
        acc_div = diff[XLEN+1] ? shifted : {diff[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
        acc_nxt = (state == MUL) ? acc_mul : acc_div;
        prod    = neg_pq ? -acc_nxt : acc_nxt;
        quo     = neg_pq ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem     = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        fin     = '0;
        case (op_q)
            4'd0:                fin = prod[XLEN-1:0];
            4'd1, 4'd2, 4'd3:    fin = prod[2*XLEN-1:XLEN];
            4'd8:                fin = w_ext(1'b1, prod[XLEN-1:0]);
            4'd4, 4'd5:          fin = quo;
            4'd6, 4'd7:          fin = rem;
            4'd9, 4'd10:         fin = w_ext(1'b1, quo);
            4'd11, 4'd12:        fin = w_ext(1'b1, rem);
            default:             fin = '0;
        endcase
    end

    assign bus.stall_req_o  = bus.valid_i & rst & ~bus.ex_flush_i & (state != DONE);
    assign bus.result_o     = result_q;
    assign bus.result_vld_o = vld_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            acc      <= '0;
            opb      <= '0;
            mplier   <= '0;
            neg_pq   <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
            vld_q    <= 1'b0;
        end else if (bus.ex_flush_i) begin
            state <= IDLE;
            cnt   <= '0;
            vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.valid_i) begin
                    op_q   <= bus.op_i;
                    neg_pq <= neg_a ^ neg_b;
                    neg_r  <= neg_a;
                    cnt    <= is_w ? 7'd32 : 7'd64;
                    if (special) begin
                        result_q <= spec_res;
                        vld_q    <= 1'b1;
                        state    <= DONE;
                    end else if (is_div) begin
                        acc   <= {{XLEN{1'b0}}, is_w ? {mag_a[31:0], 32'b0} : mag_a};
                        opb   <= {{XLEN{1'b0}}, mag_b};
                        state <= DIV;
                    end else begin
                        acc    <= '0;
                        opb    <= {{XLEN{1'b0}}, mag_a};
                        mplier <= mag_b;
                        state  <= MUL;
                    end
                end
                MUL, DIV: begin
                    acc    <= acc_nxt;
                    opb    <= (state == MUL) ? opb << 1 : opb;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        result_q <= fin;
                        vld_q    <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: if (!bus.ex_stall_i) begin
                    state <= IDLE;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_041514_ex_muldiv.sv
// Directed bench for the EX-stage mul/div unit: latency, results, stall
// request, flush, DONE hold and reset behaviour.
module tb_ysyx_041514_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_041514_ex_muldiv_if #(.XLEN(64)) bus ();
    ysyx_041514_ex_muldiv #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_vec = 0;
    int n_err = 0;

    // Issue one op and hold valid until result_vld_o (bounded), then release.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input string name);
        int k;
        bit stall_ok;
        @(posedge clk); #1;
        bus.valid_i = 1'b1; bus.op_i = op; bus.src1_i = a; bus.src2_i = b;
        bus.ex_flush_i = 1'b0; bus.ex_stall_i = 1'b0;
        #1;
        stall_ok = bus.stall_req_o;
        k = 0;
        while (k < 200) begin
            @(posedge clk); #1;
            k++;
            if (bus.result_vld_o) break;
            if (!bus.stall_req_o) stall_ok = 1'b0;
        end
        n_vec++;
        if (k !== lat) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        n_vec++;
        if (bus.result_o !== exp) begin
            n_err++; $display("FAIL %s result: got %h want %h", name, bus.result_o, exp);
        end
        n_vec++;
        if (!stall_ok || bus.stall_req_o !== 1'b0) begin
            n_err++; $display("FAIL %s stall_req: busy-high %0b done-level %b want 1/0", name, stall_ok, bus.stall_req_o);
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.valid_i = 1'b1; bus.op_i = 4'd0; bus.src1_i = 64'd3; bus.src2_i = 64'd5;
        bus.ex_stall_i = 1'b0; bus.ex_flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.result_o !== 64'd0) begin n_err++; $display("FAIL reset result_o: got %h want 0", bus.result_o); end
        n_vec++;
        if (bus.result_vld_o !== 1'b0) begin n_err++; $display("FAIL reset result_vld_o: got %b want 0", bus.result_vld_o); end
        n_vec++;
        if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL reset stall_req_o: got %b want 0", bus.stall_req_o); end
        bus.valid_i = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_mul();
        run_op(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65, "MUL 3*-5");
        run_op(4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "MULHU ones*ones");
        run_op(4'd1, '1, '1, 64'd0, 65, "MULH -1*-1");
        run_op(4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "MULHSU -1*2");
        run_op(4'd8, 64'h1234_5678_0000_0006, 64'hFFFF_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 33, "MULW 6*-7");
    endtask

    task automatic test_div();
        run_op(4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "DIV ovf");
        run_op(4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "REM ovf");
        run_op(4'd5, 64'd7, 64'd0, '1, 1, "DIVU 7/0");
        run_op(4'd7, 64'd7, 64'd0, 64'd7, 1, "REMU 7/0");
        run_op(4'd9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "DIVW -7/2");
        run_op(4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, "REMW -7/2");
        run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, "DIV -20/3");
        run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, "REM -20/3");
        run_op(4'd5, 64'd100, 64'd7, 64'd14, 65, "DIVU 100/7");
        run_op(4'd7, '1, 64'd10, 64'd5, 65, "REMU max/10");
        run_op(4'd10, 64'd0, 64'd0, '1, 1, "DIVUW x/0");
        run_op(4'd13, 64'd9, 64'd3, 64'd0, 1, "op 13");
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        bus.valid_i = 1'b1; bus.op_i = 4'd4; bus.src1_i = 64'd1000; bus.src2_i = 64'd3;
        repeat (10) begin @(posedge clk); #1; end
        bus.ex_flush_i = 1'b1;
        #1;
        n_vec++;
        if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL flush stall_req_o: got %b want 0", bus.stall_req_o); end
        run_op(4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "MULW after flush");
    endtask

    task automatic test_back_to_back();
        run_op(4'd5, 64'd7, 64'd0, '1, 1, "b2b first");
        run_op(4'd7, 64'd9, 64'd0, 64'd9, 1, "b2b second");
    endtask

    task automatic test_stall_hold();
        int k;
        @(posedge clk); #1;
        bus.valid_i = 1'b1; bus.op_i = 4'd5; bus.src1_i = 64'd100; bus.src2_i = 64'd7;
        bus.ex_stall_i = 1'b1;
        k = 0;
        while (k < 200 && !bus.result_vld_o) begin @(posedge clk); #1; k++; end
        n_vec++;
        if (k !== 65) begin n_err++; $display("FAIL hold latency: got %0d want 65", k); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (bus.result_vld_o !== 1'b1 || bus.result_o !== 64'd14 || bus.stall_req_o !== 1'b0) begin
                n_err++;
                $display("FAIL hold cycle %0d: vld %b res %h req %b want 1/%h/0", i, bus.result_vld_o, bus.result_o, bus.stall_req_o, 64'd14);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
        bus.ex_stall_i = 1'b0; bus.valid_i = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.result_vld_o !== 1'b0) begin n_err++; $display("FAIL hold release vld: got %b want 0", bus.result_vld_o); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.valid_i = 1'b1; bus.op_i = 4'd0; bus.src1_i = 64'd5; bus.src2_i = 64'd7;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL rst-mid stall_req_o: got %b want 0", bus.stall_req_o); end
        @(posedge clk); #1;
        n_vec++;
        if (bus.result_o !== 64'd0 || bus.result_vld_o !== 1'b0) begin
            n_err++; $display("FAIL rst-mid outputs: res %h vld %b want 0/0", bus.result_o, bus.result_vld_o);
        end
        bus.valid_i = 1'b0;
        rst = 1'b1;
        run_op(4'd0, 64'd6, 64'd7, 64'd42, 65, "MUL after rst");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_back_to_back();
        test_stall_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
